spi_cmd_deframer: RTL and testbench
===================================

# spi_cmd_deframer

Command deframer on the MOSI side of the SPI slave, clocked directly by the mode-adjusted SPI sampling clock. Shifts MOSI bits into bytes and decodes the first byte of each chip-select frame as a read/write header with a 7-bit address. For write frames it presents each following byte with its target address. For read frames it presents the address of the next byte to serialise. Completion events are signalled as toggles so the system-clock consumer can synchronise them with a 2-FF synchroniser plus edge detect.

## Interface
- MAX_BURST, 16, data bytes accepted per frame (1..255) before overrun
- w_SPI_Clk  in  1  SPI sampling clock; MOSI sampled on rising edge
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_SPI_CS_n  in  1  chip select; high = asynchronous frame clear (see Operation)
- i_SPI_MOSI  in  1  serial data, MSB first
- o_Cmd_Valid  out  1  header decoded for current frame
- o_Cmd_Write  out  1  1 = write frame, 0 = read frame
- o_Addr  out  7  write: address of o_Wr_Data; read: address of next byte to fetch
- o_Wr_Data  out  8  last completed write data byte
- o_Wr_Toggle  out  1  flips once per completed write data byte
- o_Rd_Toggle  out  1  flips once per read-fetch request
- o_Byte_Count  out  8  data bytes completed in current frame
- o_Frame_Err  out  1  burst overrun occurred in current/last frame

## Operation
- States: HDR, DATA, OVERRUN. Each state uses the 3-bit bit counter and 8-bit shift register.
- Bytes are assembled MSB first. A byte completes on the rising edge where the bit counter is 7. The counter wraps 7→0.
- HDR byte complete: latch o_Cmd_Write = bit7, base address = bits[6:0], set o_Cmd_Valid, go to DATA.
  - Read frame: on the same edge, o_Addr = base and o_Rd_Toggle flips (prefetch of byte 0).
- DATA byte complete, write frame: o_Wr_Data = byte, o_Addr = address of that byte, o_Wr_Toggle flips, o_Byte_Count +1.
- DATA byte complete, read frame: MOSI content is ignored and o_Byte_Count +1. If o_Byte_Count+1 < MAX_BURST, o_Addr = next address and o_Rd_Toggle flips.
- Address arithmetic is 7-bit, modulo 128 (0x7F+1 → 0x00).
- When o_Byte_Count reaches MAX_BURST, go to OVERRUN and set o_Frame_Err. Further bits are ignored, with no toggles and no count change.
- i_SPI_CS_n high (asynchronous, any state) clears:
  - bit counter
  - shift register
  - state → HDR
  - o_Cmd_Valid
  - o_Byte_Count
- The following are retained through CS_n high so the consumer sees no spurious events: o_Wr_Data, o_Addr, o_Cmd_Write, both toggles, o_Frame_Err.
- o_Frame_Err clears synchronously on the first w_SPI_Clk edge of the next frame.
- A partial byte at CS_n rise is discarded: no toggle, no count.
- i_Rst_L low: all outputs and internal state 0, state HDR. i_Rst_L has priority over CS_n.

## Timing
- All outputs are registered on w_SPI_Clk rising edge. There are no combinational paths from inputs.
- Header decode and read prefetch are visible after edge 8 of the frame. Write byte n (n = 0..) is visible after edge 16+8n.
- Toggle and its qualifying data/address update on the same edge. Data/address then hold for at least 8 SPI clocks, which is the consumer's CDC window.
- Read prefetch is issued ≥8 SPI clocks before the byte is needed by the TX serialiser.
- The consumer must satisfy i_Clk ≥ 4× SPI clock.
- Frame clear on CS_n high is immediate (async). No SPI edge is required after CS_n rises.

## Configuration
- SPI_CMD_DEFRAMER_ADDR_INC_EN defined: address increments by 1 per data byte (burst to consecutive registers), as above.
- Undefined: every data byte of a frame uses the header address (FIFO-port style). Toggle, count and overrun behaviour are unchanged.

## Test plan
- Reset, then write frame 0x85, 0xA1, 0xB2 → o_Cmd_Write=1, o_Addr=0x05 with o_Wr_Data=0xA1, then 0x06/0xB2 (0x05/0xB2 without INC_EN). Two o_Wr_Toggle flips, o_Byte_Count=2.
- Read frame header 0x7E followed by 3 dummy bytes → o_Rd_Toggle flips at edges 8, 16, 24, 32 (4 flips). o_Addr = 0x7E, 0x7F, 0x00, 0x01 (wrap).
- Write frame with MAX_BURST+2 data bytes → exactly MAX_BURST write toggles, then o_Frame_Err=1. Flag stays 1 after CS_n rise and clears on the first edge of the next frame.
- CS_n raised after 5 bits of a data byte, then a new frame 0x81, 0x33 → no toggle for the partial byte. The new header decodes correctly to o_Addr=0x01, o_Wr_Data=0x33.
- Assert i_Rst_L low mid-frame with CS_n low → all outputs 0 immediately. After release, the next full byte is decoded as a header.

Source files
------------

// File: rtl/spi_cmd_deframer.sv
// spi_cmd_deframer: MOSI-side command deframer for the SPI slave.
// Runs on the SPI sampling clock. The first byte of each chip-select frame
// is a header {rw, addr[6:0]}. Later bytes are write data, or dummy bytes
// that pace read prefetches. Completion events are toggles so that a
// system-clock consumer can pick them up with a 2-FF sync plus edge detect.
//
// Build option: define SPI_CMD_DEFRAMER_ADDR_INC_EN to step the address by
// one for each data byte. Without it, every data byte of a frame uses the
// header address (FIFO-port style).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_HDR     | assembling the header byte of the frame
// ST_DATA    | assembling data / dummy bytes, burst limit not yet reached
// ST_OVERRUN | MAX_BURST data bytes done; remaining bits are ignored

module spi_cmd_deframer #(
   parameter int MAX_BURST = 16
) (
   input  logic       w_SPI_Clk,
   input  logic       i_Rst_L,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_Cmd_Valid,
   output logic       o_Cmd_Write,
   output logic [6:0] o_Addr,
   output logic [7:0] o_Wr_Data,
   output logic       o_Wr_Toggle,
   output logic       o_Rd_Toggle,
   output logic [7:0] o_Byte_Count,
   output logic       o_Frame_Err
);

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_DATA    = 2'd1,
      ST_OVERRUN = 2'd2
   } state_t;

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic [6:0] base_addr;

   logic       frame_rst_b;
   logic       byte_done;
   logic [7:0] byte_in;
   logic [7:0] cnt_inc;
   logic [6:0] addr_wr;
   logic [6:0] addr_rd_next;

   logic       hdr_done;
   logic       data_done;
   logic       wr_evt;
   logic       rd_evt;
   logic       err_set;
   logic       err_clr;

   // Per-frame state is cleared either by reset or by chip select going
   // high. Both clear to zero, so a single combined async clear is enough.
   assign frame_rst_b = i_Rst_L & ~i_SPI_CS_n;

   assign byte_done = (bit_cnt == 3'd7);
   assign byte_in   = {shift, i_SPI_MOSI};
   assign cnt_inc   = o_Byte_Count + 8'd1;

`ifdef SPI_CMD_DEFRAMER_ADDR_INC_EN
   assign addr_wr      = base_addr + o_Byte_Count[6:0];
   assign addr_rd_next = base_addr + cnt_inc[6:0];
`else
   assign addr_wr      = base_addr;
   assign addr_rd_next = base_addr;
`endif

   // State register and per-frame counters, cleared asynchronously on CS_n high
   always_ff @(posedge w_SPI_Clk or negedge frame_rst_b) begin
      if (!frame_rst_b) begin
         state        <= ST_HDR;
         bit_cnt      <= 3'd0;
         shift        <= 7'd0;
         o_Cmd_Valid  <= 1'b0;
         o_Byte_Count <= 8'd0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt + 3'd1;
         shift   <= byte_in[6:0];
         if (hdr_done)
            o_Cmd_Valid <= 1'b1;
         if (data_done)
            o_Byte_Count <= cnt_inc;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_HDR:     if (byte_done) state_nxt = ST_DATA;
         ST_DATA:    if (byte_done && (cnt_inc == MAX_B)) state_nxt = ST_OVERRUN;
         ST_OVERRUN: state_nxt = ST_OVERRUN;
         default:    state_nxt = ST_HDR;
      endcase
   end

   // Event strobes for the byte-complete edge
   always_comb begin
      hdr_done  = (state == ST_HDR)  && byte_done;
      data_done = (state == ST_DATA) && byte_done;
      wr_evt    = data_done && o_Cmd_Write;
      rd_evt    = (hdr_done && !byte_in[7])
                  || (data_done && !o_Cmd_Write && (cnt_inc < MAX_B));
      err_set   = data_done && (cnt_inc == MAX_B);
      // The first edge of a frame is the only edge seen in ST_HDR with bit 0.
      err_clr   = (state == ST_HDR) && (bit_cnt == 3'd0) && !i_SPI_CS_n;
   end

   // Consumer-facing registers that must survive CS_n high
   always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_Cmd_Write <= 1'b0;
         base_addr   <= 7'd0;
         o_Addr      <= 7'd0;
         o_Wr_Data   <= 8'd0;
         o_Wr_Toggle <= 1'b0;
         o_Rd_Toggle <= 1'b0;
         o_Frame_Err <= 1'b0;
      end else begin
         if (hdr_done) begin
            o_Cmd_Write <= byte_in[7];
            base_addr   <= byte_in[6:0];
         end
         if (wr_evt) begin
            o_Wr_Data   <= byte_in;
            o_Addr      <= addr_wr;
            o_Wr_Toggle <= ~o_Wr_Toggle;
         end
         if (rd_evt) begin
            o_Addr      <= hdr_done ? byte_in[6:0] : addr_rd_next;
            o_Rd_Toggle <= ~o_Rd_Toggle;
         end
         if (err_clr)
            o_Frame_Err <= 1'b0;
         else if (err_set)
            o_Frame_Err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_cmd_deframer.sv
// Directed bench for spi_cmd_deframer: write, read with wrap, overrun,
// partial-byte discard and mid-frame reset.
module tb_spi_cmd_deframer;

   localparam int MAX_BURST = 16;
`ifdef SPI_CMD_DEFRAMER_ADDR_INC_EN
   localparam bit INC = 1'b1;
`else
   localparam bit INC = 1'b0;
`endif

   logic       w_SPI_Clk;
   logic       i_Rst_L;
   logic       i_SPI_CS_n;
   logic       i_SPI_MOSI;
   logic       o_Cmd_Valid;
   logic       o_Cmd_Write;
   logic [6:0] o_Addr;
   logic [7:0] o_Wr_Data;
   logic       o_Wr_Toggle;
   logic       o_Rd_Toggle;
   logic [7:0] o_Byte_Count;
   logic       o_Frame_Err;

   int checks   = 0;
   int failures = 0;

   logic       exp_wt;
   logic       exp_rt;
   logic [6:0] exp_addr;

   spi_cmd_deframer #(.MAX_BURST(MAX_BURST)) dut (
      .w_SPI_Clk    (w_SPI_Clk),
      .i_Rst_L      (i_Rst_L),
      .i_SPI_CS_n   (i_SPI_CS_n),
      .i_SPI_MOSI   (i_SPI_MOSI),
      .o_Cmd_Valid  (o_Cmd_Valid),
      .o_Cmd_Write  (o_Cmd_Write),
      .o_Addr       (o_Addr),
      .o_Wr_Data    (o_Wr_Data),
      .o_Wr_Toggle  (o_Wr_Toggle),
      .o_Rd_Toggle  (o_Rd_Toggle),
      .o_Byte_Count (o_Byte_Count),
      .o_Frame_Err  (o_Frame_Err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One SPI bit: data set up while the clock is low, then a full clock pulse.
   task automatic send_bit(input logic b);
      i_SPI_MOSI = b;
      #5 w_SPI_Clk = 1'b1;
      #5 w_SPI_Clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         send_bit(b[i]);
   endtask

   initial begin
      w_SPI_Clk  = 1'b0;
      i_Rst_L    = 1'b0;
      i_SPI_CS_n = 1'b1;
      i_SPI_MOSI = 1'b0;
      exp_wt     = 1'b0;
      exp_rt     = 1'b0;
      #7;
      chk("reset_outputs", {4'd0, o_Cmd_Valid, o_Cmd_Write, o_Addr, o_Wr_Data,
          o_Wr_Toggle, o_Rd_Toggle, o_Byte_Count, o_Frame_Err}, 32'd0);
      i_Rst_L = 1'b1;
      #5;

      // Write frame 0x85, 0xA1, 0xB2
      i_SPI_CS_n = 1'b0;
      send_byte(8'h85);
      chk("wr_hdr_valid", o_Cmd_Valid, 1);
      chk("wr_hdr_write", o_Cmd_Write, 1);
      chk("wr_hdr_wtog", o_Wr_Toggle, 0);
      send_byte(8'hA1);
      chk("wr0_data", o_Wr_Data, 8'hA1);
      chk("wr0_addr", o_Addr, 7'h05);
      chk("wr0_wtog", o_Wr_Toggle, 1);
      chk("wr0_cnt", o_Byte_Count, 1);
      send_byte(8'hB2);
      chk("wr1_data", o_Wr_Data, 8'hB2);
      chk("wr1_addr", o_Addr, INC ? 7'h06 : 7'h05);
      chk("wr1_wtog", o_Wr_Toggle, 0);
      chk("wr1_cnt", o_Byte_Count, 2);
      chk("wr_rtog", o_Rd_Toggle, 0);
      #3 i_SPI_CS_n = 1'b1;
      #2;
      chk("cs_clr_valid", o_Cmd_Valid, 0);
      chk("cs_clr_cnt", o_Byte_Count, 0);
      chk("cs_keep_data", o_Wr_Data, 8'hB2);
      chk("cs_keep_write", o_Cmd_Write, 1);
      #5;

      // Read frame 0x7E + 3 dummy bytes, address wraps past 0x7F
      i_SPI_CS_n = 1'b0;
      send_byte(8'h7E);
      exp_rt = ~exp_rt;
      chk("rd_hdr_write", o_Cmd_Write, 0);
      chk("rd_hdr_addr", o_Addr, 7'h7E);
      chk("rd_hdr_rtog", o_Rd_Toggle, exp_rt);
      for (int k = 1; k <= 3; k++) begin
         send_byte(8'hFF);
         exp_rt   = ~exp_rt;
         exp_addr = INC ? 7'(7'h7E + k) : 7'h7E;
         chk("rd_addr", o_Addr, exp_addr);
         chk("rd_rtog", o_Rd_Toggle, exp_rt);
         chk("rd_cnt", o_Byte_Count, k);
      end
      chk("rd_wtog", o_Wr_Toggle, exp_wt);
      #3 i_SPI_CS_n = 1'b1;
      #7;

      // Overrun: MAX_BURST+2 data bytes on a write frame to 0x10
      i_SPI_CS_n = 1'b0;
      send_byte(8'h90);
      for (int i = 0; i < MAX_BURST + 2; i++) begin
         send_byte(8'(8'h40 + i));
         if (i < MAX_BURST) begin
            exp_wt = ~exp_wt;
            chk("ovr_cnt", o_Byte_Count, i + 1);
            chk("ovr_addr", o_Addr, INC ? 7'(7'h10 + i) : 7'h10);
         end else begin
            chk("ovr_cnt_hold", o_Byte_Count, MAX_BURST);
         end
         chk("ovr_wtog", o_Wr_Toggle, exp_wt);
      end
      chk("ovr_err", o_Frame_Err, 1);
      chk("ovr_last_data", o_Wr_Data, 8'(8'h40 + MAX_BURST - 1));
      #3 i_SPI_CS_n = 1'b1;
      #7;
      chk("ovr_err_keep", o_Frame_Err, 1);
      i_SPI_CS_n = 1'b0;
      send_bit(1'b1);
      chk("ovr_err_clr", o_Frame_Err, 0);
      #3 i_SPI_CS_n = 1'b1;
      #7;

      // Partial data byte dropped at CS_n rise, then new frame 0x81, 0x33
      i_SPI_CS_n = 1'b0;
      send_byte(8'h82);
      for (int i = 0; i < 5; i++)
         send_bit(1'b1);
      #3 i_SPI_CS_n = 1'b1;
      #7;
      chk("part_wtog", o_Wr_Toggle, exp_wt);
      chk("part_cnt", o_Byte_Count, 0);
      i_SPI_CS_n = 1'b0;
      send_byte(8'h81);
      send_byte(8'h33);
      exp_wt = ~exp_wt;
      chk("new_addr", o_Addr, 7'h01);
      chk("new_data", o_Wr_Data, 8'h33);
      chk("new_wtog", o_Wr_Toggle, exp_wt);
      chk("new_cnt", o_Byte_Count, 1);
      #3 i_SPI_CS_n = 1'b1;
      #7;

      // Reset mid-frame with CS_n low
      i_SPI_CS_n = 1'b0;
      send_byte(8'h85);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      i_Rst_L = 1'b0;
      #1;
      chk("midrst_outputs", {4'd0, o_Cmd_Valid, o_Cmd_Write, o_Addr, o_Wr_Data,
          o_Wr_Toggle, o_Rd_Toggle, o_Byte_Count, o_Frame_Err}, 32'd0);
      #4 i_Rst_L = 1'b1;
      #5;
      exp_wt = 1'b0;
      send_byte(8'h83);
      chk("post_rst_valid", o_Cmd_Valid, 1);
      chk("post_rst_write", o_Cmd_Write, 1);
      send_byte(8'h5A);
      exp_wt = ~exp_wt;
      chk("post_rst_addr", o_Addr, 7'h03);
      chk("post_rst_data", o_Wr_Data, 8'h5A);
      chk("post_rst_wtog", o_Wr_Toggle, exp_wt);
      #3 i_SPI_CS_n = 1'b1;
      #7;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
